// File: rtl/sram_like_responder_if.sv
// Bus between an SRAM-like master and the responder.
// A request is accepted on a rising edge where req && addr_ok; the master holds req and its fields until then.
// Each accepted request is completed, in acceptance order, by a one-cycle data_ok; rdata is valid only with data_ok.
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_hold;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata, addr_hold,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, addr_hold,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_responder.sv
// Word-organised memory that answers SRAM-like requests after a fixed latency,
// with up to QDEPTH responses in flight, returned strictly in acceptance order.
module sram_like_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 4
) (
  input logic                   clk,
  input logic                   rst,
  sram_like_responder_if.slave  bus
);
  localparam int unsigned PW    = $clog2(QDEPTH);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       qdata_q [QDEPTH];
  logic [3:0]        cd_q [QDEPTH];
  logic [3:0]        cd_d [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        be;
  logic              addr_ok;
  logic              push;
  logic              pop;
  logic              unused_addr;

  assign widx        = bus.addr[ADDR_W+1:2];
  assign unused_addr = ^bus.addr[31:ADDR_W+2];

  always_comb begin
    be = 4'b0000;
    case (bus.size)
      2'd0:    be = 4'b0001 << bus.addr[1:0];
      2'd1:    be = bus.addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Occupancy is the registered count, so a same-cycle pop never frees a slot early.
  assign addr_ok = !rst && !bus.addr_hold && (count_q < (PW+1)'(QDEPTH));
  assign push    = bus.req && addr_ok;
  assign pop     = !rst && (count_q != '0) && (cd_q[rd_ptr_q] == 4'd0);

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = pop;
  assign bus.rdata   = pop ? qdata_q[rd_ptr_q] : 32'd0;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    for (int i = 0; i < QDEPTH; i++) begin
      cd_d[i] = (cd_q[i] == 4'd0) ? 4'd0 : cd_q[i] - 4'd1;
      if (push && (wr_ptr_q == PW'(i))) begin
        cd_d[i] = 4'(LATENCY - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        cd_q[i] <= 4'd0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < QDEPTH; i++) begin
        cd_q[i] <= cd_d[i];
      end
    end
  end

  // Read data is snapshotted at acceptance; later writes do not alter a queued response.
  always_ff @(posedge clk) begin
    if (push && !bus.wr) begin
      qdata_q[wr_ptr_q] <= mem_q[widx];
    end
  end

  always_ff @(posedge clk) begin
    if (push && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// Directed and randomized checks of sram_like_responder against a transaction-level model.
module tb_sram_like_responder;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 3;
  localparam int unsigned QD     = 4;
  localparam int unsigned WORDS  = 1 << ADDR_W;

  logic clk;
  logic rst;
  sram_like_responder_if bus ();

  sram_like_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: memory image plus the queue of promised responses
  logic [31:0] mem_m [WORDS];
  logic [31:0] exp_q [$];
  int          due_q [$];
  bit          isrd_q [$];
  int          cyc;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // driver: one clock cycle with the given inputs; checks outputs mid-cycle, then advances the model
  task automatic step(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic h, input logic rs, output logic acc);
    logic        e_aok;
    logic        e_dok;
    int          word;
    logic [3:0]  en;
    bus.req = r; bus.wr = w; bus.size = sz; bus.addr = a; bus.wdata = wd; bus.addr_hold = h;
    rst = rs;
    @(negedge clk);
    e_aok = !rs && !h && (exp_q.size() < QD);
    e_dok = !rs && (exp_q.size() > 0) && (due_q[0] == cyc);
    chk("addr_ok", 32'(bus.addr_ok), 32'(e_aok));
    chk("data_ok", 32'(bus.data_ok), 32'(e_dok));
    if (!e_dok) chk("rdata_idle", bus.rdata, 32'd0);
    else if (isrd_q[0]) chk("rdata", bus.rdata, exp_q[0]);
    @(posedge clk);
    acc = 1'b0;
    if (rs) begin
      exp_q.delete(); due_q.delete(); isrd_q.delete();
    end else begin
      if (e_dok) begin
        void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(isrd_q.pop_front());
      end
      if (r && e_aok) begin
        acc  = 1'b1;
        word = int'((a >> 2) % WORDS);
        exp_q.push_back(w ? 32'd0 : mem_m[word]);
        isrd_q.push_back(!w);
        due_q.push_back(cyc + LAT);
        if (w) begin
          en = lanes(sz, a[1:0]);
          for (int b = 0; b < 4; b++) if (en[b]) mem_m[word][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 30) begin
      step(1'b1, w, sz, a, wd, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $error("FAIL issue_timeout observed=not_accepted expected=accepted addr=%h", a);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      idle(1);
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] rnd;
    logic [3:0]  idx;
    logic [1:0]  lo;
    int          acc_run;
    n_cmp = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < WORDS; i++) mem_m[i] = 32'd0;

    // reset state, then first cycle after release must accept
    step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    idle(2);

    // preload words 0..15 so every later read has a defined value
    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom());
    drain();

    // full-word write then read
    issue(1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 32'h0000_0010, 32'd0);
    drain();
    chk("word_model", mem_m[4], 32'hDEAD_BEEF);

    // byte and halfword merge
    issue(1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344);
    issue(1'b1, 2'd0, 32'h0000_0022, 32'h00AA_0000);
    issue(1'b1, 2'd1, 32'h0000_0020, 32'h0000_BBCC);
    issue(1'b0, 2'd2, 32'h0000_0020, 32'd0);
    drain();
    chk("merge_model", mem_m[8], 32'h11AA_BBCC);

    // reserved size writes nothing
    issue(1'b1, 2'd3, 32'h0000_0020, 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 32'h0000_0020, 32'd0);
    drain();

    // fill and backpressure: 6 back-to-back reads
    for (int i = 0; i < 6; i++) issue(1'b0, 2'd2, 32'(i * 4), 32'd0);
    drain();

    // address wrap modulo 2^ADDR_W words
    issue(1'b1, 2'd2, 32'h0000_1000, 32'h5A5A_5A5A);
    issue(1'b0, 2'd2, 32'h0000_0000, 32'd0);
    drain();

    // reset mid-flight discards responses but keeps memory
    issue(1'b1, 2'd2, 32'h0000_0030, 32'hCAFE_F00D);
    drain();
    for (int i = 0; i < 3; i++) issue(1'b0, 2'd2, 32'(i * 4), 32'd0);
    step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    idle(8);
    issue(1'b0, 2'd2, 32'h0000_0030, 32'd0);
    drain();

    // addr_hold blocks acceptance and memory change
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 2'd2, 32'h0000_0010, 32'h0BAD_0BAD, 1'b1, 1'b0, acc);
      chk("hold_no_accept", 32'(acc), 32'd0);
    end
    acc_run = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'd0, 1'b0, 1'b0, acc);
      if (acc) acc_run++;
    end
    chk("release_accepts", 32'(acc_run), 32'd3);
    drain();

    // randomized traffic over words 0..15 with random upper address bits
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom();
      idx = 4'($urandom_range(0, 15));
      lo  = 2'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           {rnd[31:12], 6'b0, idx, lo}, $urandom(), $urandom_range(0, 4) == 0, 1'b0, acc);
    end
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the word-address width (memory holds 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, the number of cycles from acceptance to data_ok; legal range 1..15.
REQ-003 SHALL have parameter QDEPTH, default 4, the maximum number of accepted-but-unanswered requests; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  master requests a transfer this cycle.
REQ-007 wr  input  1  1 = write, 0 = read.
REQ-008 size  input  2  transfer size: 0 = byte, 1 = halfword, 2 = word, 3 = reserved.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  write data, already placed in the byte lanes selected by addr[1:0].
REQ-011 addr_hold  input  1  testbench backpressure; 1 forces addr_ok low.
REQ-012 addr_ok  output  1  request accepted this cycle when req is also 1.
REQ-013 data_ok  output  1  one-cycle pulse completing the oldest outstanding request.
REQ-014 rdata  output  32  read word, valid only while data_ok is 1.

Function
REQ-015 addr_ok SHALL equal !addr_hold && (outstanding count < QDEPTH); it is combinational and independent of req.
REQ-016 An acceptance SHALL occur on any rising edge where req && addr_ok is 1.
REQ-017 Word index SHALL be addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
REQ-018 Byte enables SHALL be:
- size 0: one byte at lane addr[1:0].
- size 1: lanes {1,0} if addr[1]=0, else lanes {3,2}; addr[0] is ignored.
- size 2: all four lanes.
- size 3: no lanes.
REQ-019 An accepted write SHALL update the enabled lanes of the memory on the acceptance edge.
REQ-020 An accepted read SHALL capture the full 32-bit memory word on the acceptance edge, after any write accepted in an earlier cycle.
REQ-021 Each acceptance SHALL push one queue entry holding the captured rdata (don't-care for writes) and a countdown initialised to LATENCY-1.
REQ-022 Every entry's countdown SHALL decrement by 1 each cycle, saturating at 0.
REQ-023 data_ok SHALL be 1 in the cycle where the head entry exists and its countdown is 0; that cycle's edge pops the head.
- Request accepted at edge T gets its data_ok no earlier than the cycle following edge T+LATENCY-1.
REQ-024 Responses SHALL be strictly in acceptance order; at most one data_ok per cycle; back-to-back acceptances yield back-to-back data_ok.
REQ-025 rdata SHALL be driven from the head entry; it is 0 when data_ok is 0.
REQ-026 Simultaneous push and pop in one cycle SHALL leave the count unchanged.
REQ-027 A pop in a cycle where the queue is full SHALL NOT raise addr_ok in that same cycle.
REQ-028 Queue read and write pointers SHALL wrap modulo QDEPTH; the count SHALL have clog2(QDEPTH)+1 bits.
REQ-029 Requests with req=1 while addr_ok=0 SHALL have no effect; the master holds them.

Reset
REQ-030 While rst=1 the block SHALL:
- clear the queue count, pointers and all countdowns;
- drive data_ok=0 and rdata=0;
- accept nothing.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 Reset asserted mid-operation SHALL discard all outstanding responses; no data_ok appears for them after rst deasserts.
REQ-033 addr_ok SHALL be 1 in the first cycle after reset deasserts, if addr_hold=0.

Verification
REQ-034 Word write then read, LATENCY=2:
- write addr 0x00000010, wdata 0xDEADBEEF, accepted at edge T -> data_ok in the cycle after edge T+1.
- read of 0x10 -> rdata=0xDEADBEEF.
REQ-035 Byte and half merge:
- word 0x11223344 at 0x20; byte write size 0, addr 0x22, wdata 0x00AA0000; half write size 1, addr 0x20, wdata 0x0000BBCC.
- read of 0x20 -> 0x11AABBCC.
REQ-036 Fill and backpressure, QDEPTH=4, LATENCY=3:
- 6 back-to-back reads -> addr_ok drops after the 4th acceptance.
- the 5th is accepted only in the cycle after the first data_ok.
- all 6 data_ok appear in order with correct data.
REQ-037 Wrap-around, ADDR_W=10:
- write 0x5A5A5A5A to 0x00001000 -> read of 0x00000000 returns 0x5A5A5A5A.
REQ-038 Reset mid-flight:
- 3 reads outstanding, rst pulsed 1 cycle -> no data_ok afterwards; addr_ok=1 in the next cycle.
- a later read of a previously written address returns the pre-reset data.
REQ-039 addr_hold:
- hold=1 for 5 cycles with req=1 -> no acceptance and no memory change.
- on release, exactly one acceptance per cycle resumes.
